// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller slice.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_ctrl_if.sv
// Configuration/control/status bundle of counter_ctrl.
interface counter_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int EVW   = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_mode;
  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             tick;
  logic             done;
  logic [EVW-1:0]   events;

  modport master (
    output cfg_valid, cfg_period, cfg_mode, start, stop, pause,
    input  cfg_ready, cnt, busy, tick, done, events
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_mode, start, stop, pause,
    output cfg_ready, cnt, busy, tick, done, events
  );
endinterface

// File: rtl/counter_ctrl_cnt_core.sv
// Modulo counter that wraps to zero after reaching the terminal count.
module cnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] cnt,
  output logic             term
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign term = (cnt == period);

  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= term ? '0 : cnt + ONE;
  end
endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/stop controller around cnt_core with wrap tick, one-shot done and event count.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int EVW   = 8
) (
  input logic          clk,
  input logic          rst_n,
  counter_ctrl_if.slave bus
);
  localparam logic [EVW-1:0] EV_ONE = EVW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_eff;
  logic             mode_q, mode_eff;
  logic             cfg_acc;
  logic             clr, en, term, wrap, ev_clr;
  logic [WIDTH-1:0] cnt;
  logic             tick_q, done_q;
  logic [EVW-1:0]   events_q;

  assign cfg_acc    = bus.cfg_valid && (state_q == IDLE);
  // Same-cycle cfg+start runs with the freshly written values.
  assign period_eff = cfg_acc ? bus.cfg_period : period_q;
  assign mode_eff   = cfg_acc ? bus.cfg_mode   : mode_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '1;
      mode_q   <= MODE_PERIODIC;
    end else begin
      state_q <= state_d;
      if (cfg_acc) begin
        period_q <= bus.cfg_period;
        mode_q   <= bus.cfg_mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    wrap    = 1'b0;
    ev_clr  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          state_d = RUN;
          clr     = 1'b1;
          ev_clr  = 1'b1;
        end
        RUN: if (bus.pause) begin
          state_d = PAUSED;
        end else begin
          en = 1'b1;
          if (term) begin
            wrap = 1'b1;
            if (mode_eff == MODE_ONESHOT) state_d = DONE;
          end
        end
        PAUSED: if (!bus.pause) state_d = RUN;
        DONE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .period (period_eff),
    .cnt    (cnt),
    .term   (term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      events_q <= '0;
    end else begin
      tick_q <= wrap;
      done_q <= wrap && (mode_eff == MODE_ONESHOT);
      if (ev_clr)
        events_q <= '0;
      else if (wrap && (events_q != '1))
        events_q <= events_q + EV_ONE;
    end
  end

  assign bus.cnt       = cnt;
  assign bus.busy      = (state_q == RUN) || (state_q == PAUSED);
  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;
  assign bus.events    = events_q;
endmodule
